// File: rtl/cache_pkg.sv
// Shared cache-coherence types: transaction encodings, arbiter states and
// type-classification helpers.
package cache_pkg;

  localparam int unsigned L1_NUM = 2;

  typedef enum logic [3:0] {
    TT_READ    = 4'd0,
    TT_READX   = 4'd1,
    TT_UPGR    = 4'd2,
    TT_FLUSH   = 4'd3,
    TT_INV_ACK = 4'd4,
    TT_ACK     = 4'd5,
    TT_WRITE   = 4'd6,
    TT_INV     = 4'd7,
    TT_REPLY   = 4'd8,
    TT_REPLY_D = 4'd9
  } transaction_type;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_RSP
  } arb_state_type;

  // Requests that leave the arbiter waiting for a directory reply.
  function automatic logic needs_reply(transaction_type t);
    return (t == TT_READ) || (t == TT_READX) || (t == TT_UPGR);
  endfunction

  // Transaction types an L1 is allowed to originate.
  function automatic logic is_l1_legal(logic [3:0] t);
    return (t == TT_READ)    || (t == TT_READX) || (t == TT_UPGR)  ||
           (t == TT_FLUSH)   || (t == TT_INV_ACK) || (t == TT_ACK) ||
           (t == TT_WRITE);
  endfunction

  // Response types that complete an outstanding request.
  function automatic logic is_reply(logic [3:0] t);
    return (t == TT_REPLY) || (t == TT_REPLY_D);
  endfunction

endpackage

// File: rtl/coh_req_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or after ptr,
// wrapping around the request vector.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan N candidates starting at ptr; the first hit wins.
  always_comb begin
    int unsigned cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/coh_req_arbiter.sv
// Round-robin arbiter funnelling L1 coherence requests to the directory,
// one transaction outstanding at a time, with illegal-type and response
// timeout detection.
module coh_req_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned L1_NUM  = cache_pkg::L1_NUM,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [L1_NUM-1:0]                 req_valid,
  output logic [L1_NUM-1:0]                 req_ready,
  input  logic [L1_NUM-1:0][3:0]            req_type,
  input  logic [L1_NUM-1:0][ADDR_W-1:0]     req_addr,
  output logic                              dir_valid,
  input  logic                              dir_ready,
  output logic [3:0]                        dir_type,
  output logic [ADDR_W-1:0]                 dir_addr,
  output logic [$clog2(L1_NUM)-1:0]         dir_src,
  input  logic                              rsp_valid,
  input  logic [3:0]                        rsp_type,
  input  logic [$clog2(L1_NUM)-1:0]         rsp_dst,
  output logic                              err_illegal,
  output logic                              err_timeout
);

  localparam int unsigned IDX_W = $clog2(L1_NUM);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_type     state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  src_q, src_d;
  logic              dir_valid_q, dir_valid_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_timeout_q, err_timeout_d;

  logic [L1_NUM-1:0] pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  rr_pick #(
    .N     (L1_NUM),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next-state, capture and error-pulse logic for the arbitration FSM.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    wait_cnt_d    = wait_cnt_q;
    type_d        = type_q;
    addr_d        = addr_q;
    src_d         = src_q;
    err_illegal_d = 1'b0;
    err_timeout_d = 1'b0;
    req_ready     = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (rst_n && pick_any) begin
          // Illegal types are still consumed and still rotate priority.
          req_ready = pick_grant;
          rr_ptr_d  = (pick_idx == IDX_W'(L1_NUM - 1)) ? '0 : pick_idx + 1'b1;
          if (is_l1_legal(req_type[pick_idx])) begin
            type_d  = req_type[pick_idx];
            addr_d  = req_addr[pick_idx];
            src_d   = pick_idx;
            state_d = ARB_ISSUE;
          end else begin
            err_illegal_d = 1'b1;
          end
        end
      end
      ARB_ISSUE: begin
        if (dir_ready) begin
          if (needs_reply(transaction_type'(type_q))) begin
            state_d    = ARB_WAIT_RSP;
            wait_cnt_d = '0;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      ARB_WAIT_RSP: begin
        // A matching reply wins over a timeout expiring in the same cycle.
        if (rsp_valid && (rsp_dst == src_q) && is_reply(rsp_type)) begin
          state_d = ARB_IDLE;
        end else if (32'(wait_cnt_q) + 1 >= TIMEOUT) begin
          err_timeout_d = 1'b1;
          state_d       = ARB_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    dir_valid_d = (state_d == ARB_ISSUE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      rr_ptr_q      <= '0;
      wait_cnt_q    <= '0;
      type_q        <= '0;
      addr_q        <= '0;
      src_q         <= '0;
      dir_valid_q   <= 1'b0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      wait_cnt_q    <= wait_cnt_d;
      type_q        <= type_d;
      addr_q        <= addr_d;
      src_q         <= src_d;
      dir_valid_q   <= dir_valid_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign dir_valid   = dir_valid_q;
  assign dir_type    = type_q;
  assign dir_addr    = addr_q;
  assign dir_src     = src_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_coh_req_arbiter.sv
// Directed bench for coh_req_arbiter with hand-computed expectations.
module tb_coh_req_arbiter;
  import cache_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][3:0]  req_type;
  logic [1:0][31:0] req_addr;
  logic             dir_valid;
  logic             dir_ready;
  logic [3:0]       dir_type;
  logic [31:0]      dir_addr;
  logic [0:0]       dir_src;
  logic             rsp_valid;
  logic [3:0]       rsp_type;
  logic [0:0]       rsp_dst;
  logic             err_illegal;
  logic             err_timeout;

  int total = 0;
  int bad   = 0;

  coh_req_arbiter #(
    .L1_NUM  (2),
    .ADDR_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_type    (req_type),
    .req_addr    (req_addr),
    .dir_valid   (dir_valid),
    .dir_ready   (dir_ready),
    .dir_type    (dir_type),
    .dir_addr    (dir_addr),
    .dir_src     (dir_src),
    .rsp_valid   (rsp_valid),
    .rsp_type    (rsp_type),
    .rsp_dst     (rsp_dst),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_type[0] = TT_READ;  req_addr[0] = 32'h100;
    req_type[1] = TT_READ;  req_addr[1] = 32'h200;
    dir_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_type  = TT_REPLY;
    rsp_dst   = 1'b0;
    tick();
    tick();
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_dir_valid", 64'(dir_valid), 64'h0);
    check("rst_dir_type",  64'(dir_type),  64'h0);
    check("rst_dir_addr",  64'(dir_addr),  64'h0);
    check("rst_dir_src",   64'(dir_src),   64'h0);
    check("rst_err_ill",   64'(err_illegal), 64'h0);
    check("rst_err_to",    64'(err_timeout), 64'h0);

    // Both L1s request Read; L1-0 wins first, then L1-1.
    rst_n = 1'b1;
    #1;
    check("rr_first_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b10;
    dir_ready = 1'b1;
    #1;
    check("issue0_valid", 64'(dir_valid), 64'h1);
    check("issue0_src",   64'(dir_src),   64'h0);
    check("issue0_addr",  64'(dir_addr),  64'h100);
    check("issue0_type",  64'(dir_type),  64'(TT_READ));
    check("issue0_rdy0",  64'(req_ready), 64'h0);
    tick();
    dir_ready = 1'b0;
    rsp_valid = 1'b1; rsp_type = TT_REPLY_D; rsp_dst = 1'b0;
    #1;
    check("wait0_dir_valid", 64'(dir_valid), 64'h0);
    check("wait0_req_ready", 64'(req_ready), 64'h0);
    tick();
    rsp_valid = 1'b0;
    #1;
    check("rr_second_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    dir_ready = 1'b1;
    #1;
    check("issue1_src",  64'(dir_src),  64'h1);
    check("issue1_addr", 64'(dir_addr), 64'h200);
    tick();
    dir_ready = 1'b0;
    rsp_valid = 1'b1; rsp_type = TT_REPLY; rsp_dst = 1'b1;
    tick();
    rsp_valid = 1'b0;

    // L1-1 Flush held off by directory for 4 cycles; no wait state after.
    req_type[1] = TT_FLUSH; req_addr[1] = 32'h340;
    req_valid = 2'b10;
    #1;
    check("flush_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("flush_hold_valid", 64'(dir_valid), 64'h1);
      check("flush_hold_type",  64'(dir_type),  64'(TT_FLUSH));
      check("flush_hold_addr",  64'(dir_addr),  64'h340);
      check("flush_hold_src",   64'(dir_src),   64'h1);
      tick();
    end
    dir_ready = 1'b1;
    #1;
    check("flush_hs_valid", 64'(dir_valid), 64'h1);
    tick();
    dir_ready = 1'b0;
    req_type[0] = TT_READX; req_addr[0] = 32'h480;
    req_valid = 2'b01;
    #1;
    check("flush_done_valid", 64'(dir_valid), 64'h0);
    check("flush_no_wait",    64'(req_ready), 64'h1);

    // L1-0 ReadX: reply in handshake cycle, wrong dst, wrong type all ignored.
    tick();
    req_valid = 2'b00;
    dir_ready = 1'b1;
    rsp_valid = 1'b1; rsp_type = TT_REPLY; rsp_dst = 1'b0;
    tick();
    dir_ready = 1'b0;
    rsp_valid = 1'b1; rsp_type = TT_REPLY; rsp_dst = 1'b1;
    req_valid = 2'b10;
    #1;
    check("hs_rsp_ignored", 64'(req_ready), 64'h0);
    tick();
    rsp_type = TT_INV_ACK; rsp_dst = 1'b0;
    #1;
    check("wrong_dst_ignored", 64'(req_ready), 64'h0);
    tick();
    rsp_type = TT_REPLY; rsp_dst = 1'b0;
    #1;
    check("wrong_type_ignored", 64'(req_ready), 64'h0);
    tick();
    rsp_valid = 1'b0;
    #1;
    check("readx_done_grant", 64'(req_ready), 64'h2);
    req_valid = 2'b00;

    // L1-0 Upgr with no response: timeout after 8 wait cycles.
    req_type[0] = TT_UPGR; req_addr[0] = 32'h5C0;
    req_valid = 2'b01;
    #1;
    check("upgr_grant_wrap", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b10;
    dir_ready = 1'b1;
    tick();
    dir_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("to_not_yet",  64'(err_timeout), 64'h0);
      check("to_wait_rdy", 64'(req_ready),   64'h0);
      tick();
    end
    check("to_pulse",     64'(err_timeout), 64'h1);
    check("to_dir_valid", 64'(dir_valid),   64'h0);
    check("to_l1_1_rdy",  64'(req_ready),   64'h2);
    req_valid = 2'b00;
    tick();
    check("to_pulse_end", 64'(err_timeout), 64'h0);

    // Illegal types are consumed, flagged, not forwarded, and rotate rr_ptr.
    req_type[0] = TT_INV;
    req_valid = 2'b01;
    #1;
    check("ill_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    #1;
    check("ill_pulse",     64'(err_illegal), 64'h1);
    check("ill_dir_valid", 64'(dir_valid),   64'h0);
    tick();
    check("ill_pulse_end", 64'(err_illegal), 64'h0);
    check("ill_dir_idle",  64'(dir_valid),   64'h0);
    req_type[1] = 4'hF;
    req_valid = 2'b10;
    #1;
    check("ill2_ready", 64'(req_ready), 64'h2);
    tick();
    req_type[0] = TT_READ;
    req_valid = 2'b11;
    #1;
    check("ill_ptr_adv", 64'(req_ready), 64'h1);
    req_valid = 2'b00;

    // Reset during WAIT_RSP abandons the transaction silently.
    req_type[1] = TT_READ; req_addr[1] = 32'h6C0;
    req_valid = 2'b10;
    #1;
    check("rstw_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    dir_ready = 1'b1;
    tick();
    dir_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    req_valid = 2'b11;
    tick();
    check("rstw_req_ready", 64'(req_ready),   64'h0);
    check("rstw_dir_valid", 64'(dir_valid),   64'h0);
    check("rstw_dir_addr",  64'(dir_addr),    64'h0);
    check("rstw_dir_src",   64'(dir_src),     64'h0);
    check("rstw_dir_type",  64'(dir_type),    64'h0);
    check("rstw_err_to",    64'(err_timeout), 64'h0);
    check("rstw_err_ill",   64'(err_illegal), 64'h0);
    rst_n = 1'b1;
    #1;
    check("rstw_idle_grant", 64'(req_ready), 64'h1);
    req_valid = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rstw_no_timeout", 64'(err_timeout), 64'h0);
      check("rstw_quiet",      64'(dir_valid),   64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
